// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing one W-bit channel between N
// requesters, with a registered valid/ready output stage.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester request (N)
//   in         packed payloads, requester i at in[i*W +: W]
//   ack        combinational one-hot: word of requester i captured this cycle
//   out_data   registered payload of the granted requester
//   out_sel    registered index of the requester whose word is in out_data
//   out_valid  out_data/out_sel hold an unaccepted word
//   out_ready  downstream accepts when out_valid && out_ready
module rr_mux_arbiter #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         in,
    output logic [N-1:0]           ack,
    output logic [W-1:0]           out_data,
    output logic [$clog2(N)-1:0]   out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned SW  = $clog2(N);
    localparam int unsigned SW1 = SW + 1;

    logic [SW-1:0] ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;

    logic          can_load;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_word;
    logic [SW:0]   idx_sum;

    // Capture allowed when the buffer is empty or being drained this cycle
    assign can_load = !out_valid_q || out_ready;

    // Scan from ptr upward, wrapping modulo N (one extra bit avoids overflow)
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx_sum   = '0;
        if (can_load && !rst) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx_sum = {1'b0, ptr_q} + SW1'(k);
                if (idx_sum >= SW1'(N)) begin
                    idx_sum = idx_sum - SW1'(N);
                end
                if (!grant_vld && req[idx_sum[SW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx_sum[SW-1:0];
                end
            end
        end
    end

    // Shared word mux driven by the grant index
    always_comb begin
        grant_word = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_word = in[i*W +: W];
            end
        end
    end

    // One-hot acknowledge for the winning requester
    always_comb begin
        ack = '0;
        if (grant_vld) begin
            ack[grant_idx] = 1'b1;
        end
    end

    // Output buffer and pointer next state
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (grant_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_word;
            out_sel_d   = grant_idx;
            ptr_d       = (grant_idx == SW'(N - 1)) ? '0 : SW'(grant_idx + SW'(1));
        end else if (out_ready) begin
            // Either accepted with nothing to replace it, or already empty
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: vector table on an N=2 instance, hand sequences
// and randomized traffic against a reference model on an N=3 instance.
module tb_rr_mux_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=2, W=32 instance
    logic        rst2;
    logic [1:0]  req2;
    logic [63:0] in2;
    logic [1:0]  ack2;
    logic [31:0] data2;
    logic [0:0]  sel2;
    logic        valid2;
    logic        rdy2;

    rr_mux_arbiter #(.W(32), .N(2)) u_dut2 (
        .clk(clk), .rst(rst2), .req(req2), .in(in2), .ack(ack2),
        .out_data(data2), .out_sel(sel2), .out_valid(valid2), .out_ready(rdy2)
    );

    // N=3, W=16 instance
    logic        rst3;
    logic [2:0]  req3;
    logic [47:0] in3;
    logic [2:0]  ack3;
    logic [15:0] data3;
    logic [1:0]  sel3;
    logic        valid3;
    logic        rdy3;

    rr_mux_arbiter #(.W(16), .N(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req(req3), .in(in3), .ack(ack3),
        .out_data(data3), .out_sel(sel3), .out_valid(valid3), .out_ready(rdy3)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rdy;
        logic [1:0]  ack;
        logic        valid;
        logic [31:0] data;
        logic        sel;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] rq, input logic [31:0] d0,
                       input logic [31:0] d1, input logic rd, input logic [1:0] a,
                       input logic v, input logic [31:0] d, input logic s);
        vec_t t;
        t.rst = r; t.req = rq; t.d0 = d0; t.d1 = d1; t.rdy = rd;
        t.ack = a; t.valid = v; t.data = d; t.sel = s;
        vecs.push_back(t);
    endtask

    // Reference model for the N=3 instance: buffered word plus the index
    // that gets first look at the next arbitration
    logic        m_valid;
    logic [15:0] m_data;
    int          m_sel;
    int          m_ptr;

    task automatic step3(input logic r, input logic [2:0] rq, input logic [47:0] din,
                         input logic rd);
        int g;
        int idx;
        @(negedge clk);
        rst3 = r; req3 = rq; in3 = din; rdy3 = rd;
        #1;
        g = -1;
        if (!r && (!m_valid || rd)) begin
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (g < 0 && rq[idx[1:0]]) g = idx;
            end
        end
        check("n3_ack",   64'(ack3),   (g < 0) ? 64'd0 : 64'(1 << g));
        check("n3_valid", 64'(valid3), 64'(m_valid));
        check("n3_data",  64'(data3),  64'(m_data));
        check("n3_sel",   64'(sel3),   64'(m_sel));
        if (r) begin
            m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = din[g*16 +: 16];
            m_sel   = g;
            m_ptr   = (g + 1) % 3;
        end else if (rd) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord_a [5];
        int ord_b [4];
        rst2 = 1'b1; req2 = '0; in2 = '0; rdy2 = 1'b1;
        rst3 = 1'b1; req3 = '0; in3 = '0; rdy3 = 1'b1;
        repeat (2) @(posedge clk);

        //   rst req  d0          d1     rdy | ack   v  data        sel
        add(1, 2'b11, 0,          0,     1,  2'b00, 0, 0,          0); // reset, ack forced low
        add(0, 2'b01, 32'hDEADBEEF, 0,   1,  2'b01, 0, 0,          0); // single requester
        add(0, 2'b00, 0,          0,     1,  2'b00, 1, 32'hDEADBEEF, 0);
        add(0, 2'b00, 0,          0,     1,  2'b00, 0, 32'hDEADBEEF, 0);
        add(1, 2'b00, 0,          0,     1,  2'b00, 0, 32'hDEADBEEF, 0);
        add(0, 2'b11, 32'hA,      32'hB, 1,  2'b01, 0, 0,          0); // alternation
        add(0, 2'b11, 32'hA,      32'hB, 1,  2'b10, 1, 32'hA,      0);
        add(0, 2'b11, 32'hA,      32'hB, 1,  2'b01, 1, 32'hB,      1);
        add(0, 2'b11, 32'hA,      32'hB, 1,  2'b10, 1, 32'hA,      0);
        add(0, 2'b10, 32'hA,      32'h55, 1, 2'b10, 1, 32'hB,      1); // capture 0x55
        for (int i = 0; i < 4; i++)
            add(0, 2'b11, 32'hA,  32'h55, 0, 2'b00, 1, 32'h55,     1); // backpressure
        add(0, 2'b11, 32'hA,      32'h55, 1, 2'b01, 1, 32'h55,     1); // release
        add(0, 2'b00, 32'hA,      32'h55, 1, 2'b00, 1, 32'hA,      0);
        add(0, 2'b01, 32'h11,     0,     0,  2'b01, 0, 32'hA,      0); // withdrawal
        add(0, 2'b11, 32'h22,     32'h33, 0, 2'b00, 1, 32'h11,     0);
        add(0, 2'b11, 32'h22,     32'h33, 0, 2'b00, 1, 32'h11,     0);
        add(0, 2'b01, 32'h22,     32'h33, 0, 2'b00, 1, 32'h11,     0);
        add(0, 2'b01, 32'h22,     32'h33, 1, 2'b01, 1, 32'h11,     0);
        add(0, 2'b00, 32'h22,     32'h33, 1, 2'b00, 1, 32'h22,     0);
        add(0, 2'b10, 32'h22,     32'h77, 0, 2'b10, 0, 32'h22,     0); // reset mid-op
        add(0, 2'b11, 32'h22,     32'h77, 0, 2'b00, 1, 32'h77,     1);
        add(1, 2'b11, 32'h22,     32'h77, 0, 2'b00, 1, 32'h77,     1);
        add(0, 2'b11, 32'h88,     32'h99, 1, 2'b01, 0, 0,          0);
        add(0, 2'b00, 32'h88,     32'h99, 1, 2'b00, 1, 32'h88,     0);
        add(0, 2'b00, 32'h88,     32'h99, 1, 2'b00, 0, 32'h88,     0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst2 = vecs[i].rst; req2 = vecs[i].req;
            in2 = {vecs[i].d1, vecs[i].d0}; rdy2 = vecs[i].rdy;
            #1;
            check($sformatf("n2_ack[%0d]", i),   64'(ack2),   64'(vecs[i].ack));
            check($sformatf("n2_valid[%0d]", i), 64'(valid2), 64'(vecs[i].valid));
            check($sformatf("n2_data[%0d]", i),  64'(data2),  64'(vecs[i].data));
            check($sformatf("n2_sel[%0d]", i),   64'(sel2),   64'(vecs[i].sel));
        end

        // N=3 wrap sequences
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
        ord_a = '{0, 1, 2, 0, 1};
        ord_b = '{0, 2, 0, 2};
        for (int k = 0; k < 5; k++) begin
            step3(1'b0, 3'b111, {16'h3030, 16'h2020, 16'h1010}, 1'b1);
            check("n3_wrap111_ack", 64'(ack3), 64'(1 << ord_a[k]));
        end
        step3(1'b1, 3'b000, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step3(1'b0, 3'b101, {16'h3030, 16'h2020, 16'h1010}, 1'b1);
            check("n3_wrap101_ack", 64'(ack3), 64'(1 << ord_b[k]));
        end
        step3(1'b0, 3'b000, '0, 1'b1);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            step3(($urandom_range(0, 49) == 0),
                  3'($urandom),
                  {16'($urandom), 16'($urandom), 16'($urandom)},
                  ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
